// File: rtl/autoconfig_sequencer_pkg.sv
// autoconfig_sequencer_pkg: shared offsets, state encoding and defaults for the autoconfig responder
package autoconfig_sequencer_pkg;
    localparam int ACFG_NBOARDS = 7;
    localparam logic [6:0] ACFG_OFS_Z3BASE = 7'h22;
    localparam logic [6:0] ACFG_OFS_Z2BASE = 7'h24;
    localparam logic [6:0] ACFG_OFS_Z2LO = 7'h25;
    localparam logic [6:0] ACFG_OFS_SHUTUP = 7'h26;
    typedef enum logic [2:0] {SCAN, IDLE, RD1, RD2, ACK} acfg_state_t;
endpackage

// File: rtl/autoconfig_sequencer.sv
// autoconfig_sequencer: walks enabled boards through $E8xxxx, serving ROM nybbles and latching bases
module autoconfig_sequencer
    import autoconfig_sequencer_pkg::*;
#(
    parameter int NBOARDS = ACFG_NBOARDS,
    parameter logic [NBOARDS-1:0] Z3_MASK = 7'b0001110
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sel,
    input  logic                   rw,
    input  logic [7:1]             addr,
    input  logic [15:0]            wdata,
    output logic                   ack,
    output logic [15:0]            rdata,
    output logic [8:0]             rom_addr,
    input  logic [3:0]             rom_q,
    input  logic [NBOARDS-1:0]     board_en,
    output logic [NBOARDS-1:0]     cfg_valid,
    output logic [16*NBOARDS-1:0]  cfg_base,
    output logic                   done
);
    acfg_state_t state, next;
    logic [2:0] cur;
    logic pend;
    logic at_end, wr, z3w, z2w, shut, adv, rd_rom;
    assign at_end = cur == 3'(NBOARDS);
    assign wr = state == IDLE && sel && !rw && !done;
    assign z3w = wr && addr == ACFG_OFS_Z3BASE && Z3_MASK[cur];
    assign z2w = wr && addr == ACFG_OFS_Z2BASE && !Z3_MASK[cur];
    assign shut = wr && addr == ACFG_OFS_SHUTUP;
    assign adv = z3w || z2w || shut;
    assign rd_rom = state == IDLE && sel && rw && !done && !addr[7];
    assign ack = state == ACK;
    assign rom_addr = {cur, addr[6:1]};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= SCAN;
        else state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            SCAN: next = (at_end || board_en[cur]) ? IDLE : SCAN;
            IDLE: next = sel ? (rd_rom ? RD1 : ACK) : IDLE;
            RD1: next = RD2;
            RD2: next = ACK;
            ACK: next = pend ? SCAN : IDLE;
            default: next = SCAN;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur <= '0;
            pend <= 1'b0;
            done <= 1'b0;
            rdata <= 16'hFFFF;
            cfg_valid <= '0;
            cfg_base <= '0;
        end else begin
            if (state == SCAN) begin
                if (at_end) done <= 1'b1;
                else if (!board_en[cur]) cur <= cur + 3'd1;
            end
            if (state == IDLE) pend <= adv;
            if (adv) cur <= cur + 3'd1;
            if (z3w || z2w) begin
                cfg_valid[cur] <= 1'b1;
                cfg_base[{cur, 4'h0} +: 16] <= z3w ? wdata : {8'h00, wdata[15:8]};
            end
            if (state == RD2) rdata <= {rom_q, 12'hFFF};
            else if (state == IDLE && sel && rw && !rd_rom) rdata <= 16'hFFFF;
        end
    end
endmodule

// File: tb/tb_autoconfig_sequencer.sv
// tb_autoconfig_sequencer: scoreboard bench for the autoconfig responder
module tb_autoconfig_sequencer;
    import autoconfig_sequencer_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sel = 1'b0;
    logic rw = 1'b1;
    logic [7:1] addr = '0;
    logic [15:0] wdata = '0;
    logic [3:0] rom_q;
    logic [6:0] board_en = 7'h7F;
    logic ack, done;
    logic [15:0] rdata;
    logic [8:0] rom_addr;
    logic [6:0] cfg_valid;
    logic [111:0] cfg_base;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_sel = 0;
    logic [15:0] last = 16'hFFFF;
    logic [3:0] rom_mem [512];
    logic [8:0] ra_q;
    typedef struct {
        logic [15:0] rd;
        int lat;
        string name;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    autoconfig_sequencer dut (
        .clk(clk), .reset(reset), .sel(sel), .rw(rw), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .rom_addr(rom_addr), .rom_q(rom_q),
        .board_en(board_en), .cfg_valid(cfg_valid), .cfg_base(cfg_base), .done(done)
    );

    always #5 clk = ~clk;
    always_ff @(posedge clk) begin
        cyc <= cyc + 1;
        ra_q <= rom_addr;
        rom_q <= rom_mem[ra_q];
    end

    task automatic chk(input string name, input logic [111:0] act, input logic [111:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && ack) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ack cycle %0d got rdata %0h want no ack", cyc, rdata);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_rdata"}, 112'(rdata), 112'(mon_e.rd));
                chk({mon_e.name, "_lat"}, 112'(cyc - t_sel), 112'(mon_e.lat));
            end
        end
    end

    task automatic acc(input string name, input logic r, input logic [6:0] a, input logic [15:0] wd,
                       input int ra, input logic [15:0] exp_rd, input int lat);
        logic got;
        @(negedge clk);
        sel = 1'b1;
        rw = r;
        addr = a;
        wdata = wd;
        t_sel = cyc;
        if (r) last = exp_rd;
        sb.push_back('{last, lat, name});
        #1;
        if (ra >= 0) chk({name, "_rom_addr"}, 112'(rom_addr), 112'(ra));
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = ack;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got no ack want ack within 20 cycles", name);
        end
        sel = 1'b0;
        rw = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic rd(input string name, input logic [6:0] a, input int ra, input logic [15:0] exp_rd, input int lat);
        acc(name, 1'b1, a, 16'h0000, ra, exp_rd, lat);
    endtask

    task automatic wr(input string name, input logic [6:0] a, input logic [15:0] wd);
        acc(name, 1'b0, a, wd, -1, 16'h0000, 1);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ack"}, 112'(ack), 112'(0));
        chk({name, "_rdata"}, 112'(rdata), 112'(16'hFFFF));
        chk({name, "_valid"}, 112'(cfg_valid), 112'(0));
        chk({name, "_base"}, cfg_base, 112'(0));
        chk({name, "_done"}, 112'(done), 112'(0));
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom_mem[i] = 4'hF;
        rom_mem[9'h000] = 4'hE;
        rom_mem[9'h001] = 4'h7;
        rom_mem[9'h040] = 4'h5;
        rom_mem[9'h080] = 4'h9;
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        rd("rd00", 7'h00, 9'h000, 16'hEFFF, 3);
        rd("rd02", 7'h01, 9'h001, 16'h7FFF, 3);
        rd("rd80", 7'h40, -1, 16'hFFFF, 1);
        wr("wr4a", 7'h25, 16'h1234);
        rd("rd00_again", 7'h00, 9'h000, 16'hEFFF, 3);
        wr("wr48_b0", 7'h24, 16'h2000);
        chk("valid_b0", 112'(cfg_valid), 112'(7'b0000001));
        chk("base_b0", 112'(cfg_base[15:0]), 112'(16'h0020));
        rd("rd00_b1", 7'h00, 9'h040, 16'h5FFF, 3);
        wr("wr48_b1_z3", 7'h24, 16'h1100);
        chk("valid_b1_z2wr", 112'(cfg_valid), 112'(7'b0000001));
        rd("rd00_b1_stay", 7'h00, 9'h040, 16'h5FFF, 3);
        wr("wr44_b1", 7'h22, 16'h4000);
        chk("valid_b1", 112'(cfg_valid), 112'(7'b0000011));
        chk("base_b1", 112'(cfg_base[31:16]), 112'(16'h4000));
        rd("rd00_b2", 7'h00, 9'h080, 16'h9FFF, 3);

        reset = 1'b1;
        board_en = 7'b0000101;
        @(negedge clk);
        chk_reset_outputs("rst2");
        reset = 1'b0;
        last = 16'hFFFF;
        repeat (3) @(negedge clk);
        rd("c2_rd_b0", 7'h00, 9'h000, 16'hEFFF, 3);
        wr("c2_wr48_b0", 7'h24, 16'hE900);
        rd("c2_rd_b2", 7'h00, 9'h080, 16'h9FFF, 3);
        wr("c2_shutup_b2", 7'h26, 16'h0000);
        chk("c2_done", 112'(done), 112'(1));
        chk("c2_valid", 112'(cfg_valid), 112'(7'b0000001));
        chk("c2_base", cfg_base, {96'h0, 16'h00E9});
        rd("c2_rd_done", 7'h00, -1, 16'hFFFF, 1);
        wr("c2_wr48_done", 7'h24, 16'h3300);
        chk("c2_valid_done", 112'(cfg_valid), 112'(7'b0000001));
        chk("c2_base_done", 112'(cfg_base[15:0]), 112'(16'h00E9));

        board_en = 7'h7F;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last = 16'hFFFF;
        repeat (3) @(negedge clk);
        sel = 1'b1;
        rw = 1'b1;
        addr = 7'h00;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        sel = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        rd("post_rst_rd", 7'h00, 9'h000, 16'hEFFF, 3);
        repeat (5) @(negedge clk);
        chk("sb_empty", 112'(sb.size()), 112'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
